// File: rtl/data_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_pkg
// Purpose  : Shared state encoding, default widths and port ids for the
//            data RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package data_ram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_W_SETUP  = 3'd1;
    localparam logic [2:0] ST_W_STROBE = 3'd2;
    localparam logic [2:0] ST_W_HOLD   = 3'd3;
    localparam logic [2:0] ST_R_ACC    = 3'd4;
    localparam logic [2:0] ST_R_CAP    = 3'd5;
    localparam logic [2:0] ST_R_ACK    = 3'd6;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        W_SETUP  = ST_W_SETUP,
        W_STROBE = ST_W_STROBE,
        W_HOLD   = ST_W_HOLD,
        R_ACC    = ST_R_ACC,
        R_CAP    = ST_R_CAP,
        R_ACK    = ST_R_ACK
    } state_e;

endpackage
`default_nettype wire

// File: rtl/data_ram_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way combinational arbiter, round-robin or fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import data_ram_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic grant_id
);

    always_comb begin
        grant    = req0 | req1;
        grant_id = PORT_CPU;
        if (req0 && req1) begin
            // Round-robin hands the tie to whichever port did not win last time
            grant_id = (PRIORITY_MODE == 1) ? PORT_CPU : ~last_grant;
        end else if (req1) begin
            grant_id = PORT_DBG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_arbiter
// Purpose  : Sequences CPU and debug/DMA accesses onto a single-port RAM with
//            a tristate data bus and an edge-triggered write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_arbiter
    import data_ram_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int PRIORITY_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_read,
    output logic              ram_write
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               port_q, port_d;
    logic               last_grant_q, last_grant_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;

    logic               grant;
    logic               grant_id;
    logic               sel_we;
    logic               drive_en;
    logic               in_ack;

    rr_arbiter2 #(
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign sel_we = (grant_id == PORT_DBG) ? we1 : we0;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    port_d       = grant_id;
                    last_grant_d = grant_id;
                    addr_d       = (grant_id == PORT_DBG) ? addr1  : addr0;
                    wdata_d      = (grant_id == PORT_DBG) ? wdata1 : wdata0;
                    state_d      = sel_we ? W_SETUP : R_ACC;
                end
            end
            W_SETUP:  state_d = W_STROBE;
            W_STROBE: state_d = W_HOLD;
            W_HOLD:   state_d = IDLE;
            R_ACC:    state_d = R_CAP;
            R_CAP: begin
                // RAM output has had a full cycle to settle; capture at the edge
                state_d = R_ACK;
                if (port_q == PORT_DBG) begin
                    rdata1_d = ram_data;
                end else begin
                    rdata0_d = ram_data;
                end
            end
            R_ACK:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            port_q       <= PORT_CPU;
            last_grant_q <= PORT_DBG;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Bus drive spans setup, strobe and hold so data brackets the strobe edge
    assign drive_en  = (state_q == W_SETUP) || (state_q == W_STROBE) || (state_q == W_HOLD);
    assign ram_data  = drive_en ? wdata_q : {DATA_W{1'bz}};
    assign ram_write = (state_q == W_STROBE);
    assign ram_read  = (state_q == R_ACC) || (state_q == R_CAP);
    assign ram_addr  = addr_q;

    assign in_ack = (state_q == W_HOLD) || (state_q == R_ACK);
    assign ack0   = in_ack && (port_q == PORT_CPU);
    assign ack1   = in_ack && (port_q == PORT_DBG);
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_arbiter
// Purpose  : Directed bench: a round-robin and a fixed-priority arbiter, each
//            on its own RAM model, driven from shared request inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;

    logic [7:0] rdata0_a, rdata1_a, ram_addr_a;
    logic       ack0_a, ack1_a, ram_read_a, ram_write_a;
    wire  [7:0] bus_a;
    logic [7:0] rdata0_b, rdata1_b, ram_addr_b;
    logic       ack0_b, ack1_b, ram_read_b, ram_write_b;
    wire  [7:0] bus_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    int         wr_cnt_a = 0;
    int         viol     = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    data_ram_arbiter #(.DATA_W(8), .ADDR_W(8), .PRIORITY_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .rdata0(rdata0_a), .rdata1(rdata1_a), .ack0(ack0_a), .ack1(ack1_a),
        .ram_addr(ram_addr_a), .ram_data(bus_a), .ram_read(ram_read_a), .ram_write(ram_write_a)
    );

    data_ram_arbiter #(.DATA_W(8), .ADDR_W(8), .PRIORITY_MODE(1)) dut_fx (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .ack0(ack0_b), .ack1(ack1_b),
        .ram_addr(ram_addr_b), .ram_data(bus_b), .ram_read(ram_read_b), .ram_write(ram_write_b)
    );

    // RAM models: level read, capture on rising write strobe
    assign bus_a = ram_read_a ? mem_a[ram_addr_a] : 8'hzz;
    assign bus_b = ram_read_b ? mem_b[ram_addr_b] : 8'hzz;

    always @(posedge ram_write_a) begin
        mem_a[ram_addr_a] <= bus_a;
        wr_cnt_a++;
    end

    always @(posedge ram_write_b) begin
        mem_b[ram_addr_b] <= bus_b;
    end

    always @(negedge clk) begin
        if ((ram_read_a && ram_write_a) || (ram_read_b && ram_write_b)) viol++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    // One access on the round-robin instance; lat is 0 when no ack arrives
    task automatic do_access(input logic p, input logic w, input logic [7:0] a,
                             input logic [7:0] d, output int lat, output int whigh,
                             output int rhigh, output logic [7:0] rd);
        if (p == 1'b0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end
        lat = 0; whigh = 0; rhigh = 0;
        for (int n = 1; n <= 10; n++) begin
            tick;
            if (ram_write_a) whigh++;
            if (ram_read_a) rhigh++;
            if ((p == 1'b0 && ack0_a) || (p == 1'b1 && ack1_a)) begin
                lat = n;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        rd = p ? rdata1_a : rdata0_a;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            req0 = 1'($urandom); req1 = 1'($urandom);
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = 8'($urandom); addr1 = 8'($urandom);
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            tick;
        end
        n_checks++;
        if ({ack0_a, ack1_a, ram_read_a, ram_write_a} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl_rr: got %b want 0000", {ack0_a, ack1_a, ram_read_a, ram_write_a});
        end
        n_checks++;
        if ({ram_addr_a, rdata0_a, rdata1_a} !== 24'h0) begin
            n_fail++; $display("FAIL reset_data_rr: got %h want 000000", {ram_addr_a, rdata0_a, rdata1_a});
        end
        n_checks++;
        if ({ack0_b, ack1_b, ram_read_b, ram_write_b, ram_addr_b, rdata0_b, rdata1_b} !== 28'h0) begin
            n_fail++; $display("FAIL reset_fixed: got %h want 0", {ack0_b, ack1_b, ram_read_b, ram_write_b, ram_addr_b, rdata0_b, rdata1_b});
        end
        req0 = 1'b0; req1 = 1'b0;
        rst_n = 1'b1;
        tick;
        n_checks++;
        if ({ack0_a, ack1_a, ram_read_a, ram_write_a} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_release_idle: got %b want 0000", {ack0_a, ack1_a, ram_read_a, ram_write_a});
        end
    endtask

    task automatic test_write_read;
        int lat, wh, rh;
        logic [7:0] rd;
        do_access(1'b0, 1'b1, 8'h10, 8'hA5, lat, wh, rh, rd);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", lat); end
        n_checks++;
        if (wh !== 1) begin n_fail++; $display("FAIL wr_strobe_cycles: got %0d want 1", wh); end
        n_checks++;
        if (mem_a[8'h10] !== 8'hA5) begin n_fail++; $display("FAIL wr_ram_content: got %h want a5", mem_a[8'h10]); end
        do_access(1'b0, 1'b0, 8'h10, 8'h00, lat, wh, rh, rd);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_checks++;
        if (rh !== 2 || wh !== 0) begin n_fail++; $display("FAIL rd_strobes: read %0d write %0d want 2 0", rh, wh); end
        n_checks++;
        if (rd !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h want a5", rd); end
        tick; tick;
        n_checks++;
        if (rdata0_a !== 8'hA5) begin n_fail++; $display("FAIL rd_data_held: got %h want a5", rdata0_a); end
    endtask

    task automatic test_collision;
        int t0, t1, lat, wh, rh;
        logic [7:0] rd;
        apply_reset;
        t0 = 0; t1 = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h22;
        for (int n = 1; n <= 12; n++) begin
            tick;
            if (ack0_a && t0 == 0) begin t0 = n; req0 = 1'b0; end
            if (ack1_a && t1 == 0) begin t1 = n; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_checks++;
        if (t0 !== 3 || t1 !== 7) begin n_fail++; $display("FAIL collision_order: ack0 at %0d ack1 at %0d want 3 7", t0, t1); end
        do_access(1'b0, 1'b0, 8'h20, 8'h00, lat, wh, rh, rd);
        n_checks++;
        if (rd !== 8'h22) begin n_fail++; $display("FAIL collision_final: got %h want 22", rd); end
    endtask

    task automatic test_alternate;
        int k;
        logic   pk [8];
        int     tk [8];
        apply_reset;
        k = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        for (int n = 1; n <= 24; n++) begin
            tick;
            if ((ack0_a || ack1_a) && k < 8) begin
                pk[k] = ack1_a;
                tk[k] = n;
                k++;
            end
            if (n == 23) begin req0 = 1'b0; req1 = 1'b0; end
        end
        n_checks++;
        if (k !== 6) begin n_fail++; $display("FAIL alt_ack_count: got %0d want 6", k); end
        for (int i = 0; i < k && i < 6; i++) begin
            n_checks++;
            if (pk[i] !== 1'(i % 2) || tk[i] !== 3 + 4 * i) begin
                n_fail++; $display("FAIL alt_grant_%0d: port %0d at %0d want port %0d at %0d", i, pk[i], tk[i], i % 2, 3 + 4 * i);
            end
        end
        n_checks++;
        if (rdata0_a !== 8'h22 || rdata1_a !== 8'hA5) begin
            n_fail++; $display("FAIL alt_rdata: got %h %h want 22 a5", rdata0_a, rdata1_a);
        end
    endtask

    task automatic test_reset_mid_write;
        int lat, wh, rh, acks, wr_before;
        logic [7:0] rd;
        do_access(1'b0, 1'b1, 8'h30, 8'h5A, lat, wh, rh, rd);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL midrst_first_write: latency %0d want 3", lat); end
        wr_before = wr_cnt_a;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'hFF;
        tick;
        rst_n = 1'b0; req0 = 1'b0;
        tick;
        rst_n = 1'b1;
        acks = 0;
        for (int n = 0; n < 5; n++) begin
            if (ack0_a || ack1_a || ram_write_a) acks++;
            tick;
        end
        n_checks++;
        if (acks !== 0) begin n_fail++; $display("FAIL midrst_no_ack: got %0d activity cycles want 0", acks); end
        n_checks++;
        if (wr_cnt_a !== wr_before) begin n_fail++; $display("FAIL midrst_no_write: got %0d writes want 0", wr_cnt_a - wr_before); end
        do_access(1'b0, 1'b0, 8'h30, 8'h00, lat, wh, rh, rd);
        n_checks++;
        if (rd !== 8'h5A) begin n_fail++; $display("FAIL midrst_readback: got %h want 5a", rd); end
    endtask

    task automatic test_fixed_priority;
        int cnt0, last0, t1;
        apply_reset;
        cnt0 = 0; last0 = 0; t1 = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        for (int n = 1; n <= 24; n++) begin
            tick;
            if (ack0_b) begin
                cnt0++; last0 = n;
                if (n == 15) req0 = 1'b0;
            end
            if (ack1_b) begin
                t1 = n; req1 = 1'b0;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick;
        n_checks++;
        if (cnt0 !== 4 || last0 !== 15) begin n_fail++; $display("FAIL fixed_port0_only: %0d acks last at %0d want 4 at 15", cnt0, last0); end
        n_checks++;
        if (t1 !== 19) begin n_fail++; $display("FAIL fixed_port1_after_drop: ack1 at %0d want 19", t1); end
        n_checks++;
        if (rdata1_b !== 8'h22) begin n_fail++; $display("FAIL fixed_rdata1: got %h want 22", rdata1_b); end
    endtask

    task automatic test_invariant;
        n_checks++;
        if (viol !== 0) begin n_fail++; $display("FAIL read_write_overlap: got %0d cycles want 0", viol); end
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        test_reset;
        test_write_read;
        test_collision;
        test_alternate;
        test_reset_mid_write;
        test_fixed_priority;
        test_invariant;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
